wdt_ctrl: RTL and testbench

- Watchdog sequencer that owns the 32-bit up-counter primitive (clear / enable / init-value interface) and turns it into a complete watchdog.
- Latches timeout and pre-warning thresholds, validates keyed kicks, raises a one-cycle pre-warning interrupt, and, on expiry, holds a reset request for a fixed number of cycles.
- Sits between the APB register file (configuration, kick) and the SoC reset controller / event unit.

---
 rtl/wdt_ctrl.sv | 116 +++++++++++
 tb/tb_wdt_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: watchdog sequencer driving an external 32-bit up-counter primitive.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg_enable_i             level; arms the watchdog while high
//   cfg_timeout_i/cfg_warn_i expiry / pre-warning thresholds, captured on arm
//   cfg_lock_i               pulse; blocks disable while running
//   kick_i, kick_key_i       kick strobe and its key
//   counter_value_i          registered count from the counter primitive
//   cnt_enable_o/cnt_clear_o counter increment enable / load strobe
//   cnt_init_o               counter load value (always 0)
//   irq_warn_o               one-cycle pre-warning pulse
//   wdt_rst_req_o            reset request, held RST_CYCLES cycles on expiry
//   cfg_err_o, locked_o      sticky config error, lock status
//   state_o, expire_cnt_o    FSM state, saturating expiry count
module wdt_ctrl #(
   parameter logic [31:0] KICK_KEY   = 32'h5AFE_C0DE,
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_enable_i,
   input  logic [31:0] cfg_timeout_i,
   input  logic [31:0] cfg_warn_i,
   input  logic        cfg_lock_i,
   input  logic        kick_i,
   input  logic [31:0] kick_key_i,
   input  logic [31:0] counter_value_i,
   output logic        cnt_enable_o,
   output logic        cnt_clear_o,
   output logic [31:0] cnt_init_o,
   output logic        irq_warn_o,
   output logic        wdt_rst_req_o,
   output logic        cfg_err_o,
   output logic        locked_o,
   output logic [1:0]  state_o,
   output logic [7:0]  expire_cnt_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WARN = 2'd2, EXPIRED = 2'd3} state_e;

   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] warn_q, timeout_q;
   logic [7:0]  rst_cnt_q, expire_cnt_q;
   logic        cfg_err_q, locked_q, irq_q;
   logic        kick_ok, kick_bad, cfg_ok, disable_req, arm, enter_exp;

   assign kick_ok     = kick_i && kick_key_i == KICK_KEY;
   assign kick_bad    = kick_i && !kick_ok;
   assign cfg_ok      = cfg_timeout_i != '0 && cfg_warn_i < cfg_timeout_i;
   assign disable_req = !cfg_enable_i && !locked_q;
   assign arm         = state_q == IDLE && cfg_enable_i && cfg_ok;
   assign enter_exp   = state_d == EXPIRED && state_q != EXPIRED;

   // Priority while running: bad kick, unlocked disable, good kick, threshold.
   always_comb begin
      state_d      = state_q;
      cnt_enable_o = 1'b0;
      cnt_clear_o  = 1'b1;
      case (state_q)
         IDLE:    state_d = arm ? RUN : IDLE;
         RUN, WARN: begin
            cnt_enable_o = 1'b1;
            cnt_clear_o  = kick_ok;
            if (kick_bad)
               state_d = EXPIRED;
            else if (disable_req)
               state_d = IDLE;
            else if (kick_ok)
               state_d = RUN;
            else if (state_q == RUN && counter_value_i >= warn_q)
               state_d = WARN;
            else if (state_q == WARN && counter_value_i >= timeout_q)
               state_d = EXPIRED;
         end
         EXPIRED: state_d = rst_cnt_q == RST_LAST ? IDLE : EXPIRED;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         warn_q       <= '0;
         timeout_q    <= '0;
         rst_cnt_q    <= '0;
         expire_cnt_q <= '0;
         cfg_err_q    <= 1'b0;
         locked_q     <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= state_d == WARN && state_q != WARN;
         rst_cnt_q <= state_q == EXPIRED && state_d == EXPIRED ? rst_cnt_q + 8'd1 : '0;
         if (arm) begin
            warn_q    <= cfg_warn_i;
            timeout_q <= cfg_timeout_i;
         end
         if (state_q == IDLE)
            cfg_err_q <= cfg_enable_i ? cfg_err_q | !cfg_ok : 1'b0;
         // Expiry releases the lock even if a lock pulse arrives the same cycle.
         if (enter_exp) begin
            locked_q     <= 1'b0;
            expire_cnt_q <= expire_cnt_q == 8'hFF ? expire_cnt_q : expire_cnt_q + 8'd1;
         end else if ((state_q == RUN || state_q == WARN) && cfg_lock_i) begin
            locked_q <= 1'b1;
         end
      end
   end

   assign cnt_init_o    = '0;
   assign irq_warn_o    = irq_q;
   assign wdt_rst_req_o = state_q == EXPIRED;
   assign cfg_err_o     = cfg_err_q;
   assign locked_o      = locked_q;
   assign state_o       = state_q;
   assign expire_cnt_o  = expire_cnt_q;
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed bench for wdt_ctrl with a behavioural watchdog model and counter primitive.
module tb_wdt_ctrl;
   localparam logic [31:0] KEY     = 32'h5AFE_C0DE;
   localparam int          RST_CYC = 16;

   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        cfg_enable_i = 1'b0, cfg_lock_i = 1'b0, kick_i = 1'b0;
   logic [31:0] cfg_timeout_i = '0, cfg_warn_i = '0, kick_key_i = '0;
   logic [31:0] counter_value_i = '0;
   logic        cnt_enable_o, cnt_clear_o, irq_warn_o, wdt_rst_req_o, cfg_err_o, locked_o;
   logic [31:0] cnt_init_o;
   logic [1:0]  state_o;
   logic [7:0]  expire_cnt_o;
   int          checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   wdt_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cfg_enable_i(cfg_enable_i),
      .cfg_timeout_i(cfg_timeout_i), .cfg_warn_i(cfg_warn_i), .cfg_lock_i(cfg_lock_i),
      .kick_i(kick_i), .kick_key_i(kick_key_i), .counter_value_i(counter_value_i),
      .cnt_enable_o(cnt_enable_o), .cnt_clear_o(cnt_clear_o), .cnt_init_o(cnt_init_o),
      .irq_warn_o(irq_warn_o), .wdt_rst_req_o(wdt_rst_req_o), .cfg_err_o(cfg_err_o),
      .locked_o(locked_o), .state_o(state_o), .expire_cnt_o(expire_cnt_o)
   );

   // Counter primitive: clear beats enable, value changes on the edge after the strobe.
   always @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)          counter_value_i <= '0;
      else if (cnt_clear_o) counter_value_i <= '0;
      else if (cnt_enable_o) counter_value_i <= counter_value_i + 32'd1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: armed/warned flags, a countdown of remaining reset-request cycles, own count.
   bit          m_armed, m_warned, m_err, m_lock, m_irq;
   int          m_hold, m_exp;
   logic [31:0] m_cnt, m_to, m_wa;

   always @(posedge clk_i or negedge rst_ni) begin
      bit kv, ki, clr, en, expire;
      if (!rst_ni) begin
         m_armed = 0; m_warned = 0; m_err = 0; m_lock = 0; m_irq = 0;
         m_hold = 0; m_exp = 0; m_cnt = 0; m_to = 0; m_wa = 0;
      end else begin
         kv = kick_i && kick_key_i == KEY;
         ki = kick_i && !kv;
         clr = !m_armed || kv;
         en = m_armed;
         expire = 0;
         m_irq = 0;
         if (m_hold > 0) begin
            m_hold--;
         end else if (!m_armed) begin
            if (!cfg_enable_i) m_err = 0;
            else if (cfg_timeout_i != 0 && cfg_warn_i < cfg_timeout_i) begin
               m_armed = 1; m_warned = 0; m_to = cfg_timeout_i; m_wa = cfg_warn_i;
            end else m_err = 1;
         end else begin
            if (ki) expire = 1;
            else if (!cfg_enable_i && !m_lock) m_armed = 0;
            else if (kv) m_warned = 0;
            else if (!m_warned && m_cnt >= m_wa) begin m_warned = 1; m_irq = 1; end
            else if (m_warned && m_cnt >= m_to) expire = 1;
            if (cfg_lock_i) m_lock = 1;
            if (expire) begin
               m_armed = 0; m_warned = 0; m_hold = RST_CYC; m_lock = 0;
               if (m_exp < 255) m_exp++;
            end
         end
         m_cnt = clr ? 32'd0 : en ? m_cnt + 32'd1 : m_cnt;
      end
   end

   always @(negedge clk_i) if (rst_ni) begin
      chk("state", {30'd0, state_o}, m_hold > 0 ? 3 : !m_armed ? 0 : m_warned ? 2 : 1);
      chk("clear", cnt_clear_o, !m_armed || (kick_i && kick_key_i == KEY));
      chk("enable", cnt_enable_o, m_armed);
      chk("init", cnt_init_o, 0);
      chk("irq", irq_warn_o, m_irq);
      chk("rst_req", wdt_rst_req_o, m_hold > 0);
      chk("cfg_err", cfg_err_o, m_err);
      chk("locked", locked_o, m_lock);
      chk("expire_cnt", {24'd0, expire_cnt_o}, m_exp);
      chk("count", counter_value_i, m_cnt);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   function automatic bit cond(input int sel);
      return sel == 0 ? irq_warn_o : sel == 1 ? wdt_rst_req_o : !wdt_rst_req_o;
   endfunction

   task automatic wait_until(input string name, input int sel, input int limit, output int n);
      n = 0;
      while (!cond(sel) && n < limit) begin tick(); n++; end
      if (!cond(sel)) begin
         checks++; errors++;
         $display("FAIL %s: timeout after %0d cycles", name, n);
      end
   endtask

   task automatic arm(input logic [31:0] to, input logic [31:0] wa);
      cfg_timeout_i = to; cfg_warn_i = wa; cfg_enable_i = 1; tick();
   endtask

   initial begin
      int n, m;
      #1;
      chk("rst_state", {30'd0, state_o}, 0);
      chk("rst_clear", cnt_clear_o, 1);
      chk("rst_enable", cnt_enable_o, 0);
      chk("rst_req0", wdt_rst_req_o, 0);
      chk("rst_exp", {24'd0, expire_cnt_o}, 0);
      tick(2); rst_ni = 1; tick();
      // Free-running expiry; threshold edits after arming must not matter.
      arm(100, 80);
      chk("t1_run", {30'd0, state_o}, 1);
      cfg_timeout_i = 5; cfg_warn_i = 2;
      wait_until("t1_warn", 0, 200, n); chk("t1_warn_lat", n, 81);
      tick(); chk("t1_irq_once", irq_warn_o, 0);
      wait_until("t1_rst", 1, 200, m); chk("t1_rst_lat", n + 1 + m, 101);
      cfg_enable_i = 0;
      wait_until("t1_rstlen", 2, 100, n); chk("t1_rst_len", n, 16);
      chk("t1_idle", {30'd0, state_o}, 0);
      chk("t1_exp", {24'd0, expire_cnt_o}, 1);
      // Valid kick at cycle 50, then unlocked disable in WARN.
      arm(100, 80); tick(50);
      kick_i = 1; kick_key_i = KEY; #1;
      chk("t2_kick_clr", cnt_clear_o, 1);
      tick(); kick_i = 0;
      chk("t2_cnt0", counter_value_i, 0);
      wait_until("t2_warn", 0, 200, n); chk("t2_warn_lat", n, 81);
      cfg_enable_i = 0; tick();
      chk("t2_dis_idle", {30'd0, state_o}, 0);
      chk("t2_dis_clr", cnt_clear_o, 1);
      // Wrong key.
      arm(100, 80); tick(5);
      kick_i = 1; kick_key_i = 0; tick(); kick_i = 0; cfg_enable_i = 0;
      chk("t3_exp_state", {30'd0, state_o}, 3);
      chk("t3_rst", wdt_rst_req_o, 1);
      chk("t3_exp", {24'd0, expire_cnt_o}, 2);
      wait_until("t3_rstlen", 2, 100, n); chk("t3_rst_len", n, 16);
      // Invalid config (warn == timeout); kicks in IDLE ignored.
      arm(10, 10);
      chk("t4_err", cfg_err_o, 1);
      chk("t4_idle", {30'd0, state_o}, 0);
      kick_i = 1; tick(3); kick_i = 0;
      chk("t4_err_hold", cfg_err_o, 1);
      cfg_enable_i = 0; tick();
      chk("t4_err_clr", cfg_err_o, 0);
      // Locked: disable ignored, expiry drops the lock.
      arm(100, 80); tick(10);
      cfg_lock_i = 1; tick(); cfg_lock_i = 0;
      chk("t5_locked", locked_o, 1);
      cfg_enable_i = 0; tick(5);
      chk("t5_still_run", {30'd0, state_o}, 1);
      wait_until("t5_rst", 1, 200, m); chk("t5_rst_lat", 16 + m, 101);
      chk("t5_unlock", locked_o, 0);
      chk("t5_exp", {24'd0, expire_cnt_o}, 3);
      wait_until("t5_rstlen", 2, 100, n);
      // Kick exactly at the timeout value in WARN, then reset mid-expiry.
      arm(20, 5);
      wait_until("t6_warn", 0, 100, n); chk("t6_warn_lat", n, 6);
      tick(14);
      chk("t6_cnt20", counter_value_i, 20);
      kick_i = 1; kick_key_i = KEY; tick(); kick_i = 0;
      chk("t6_run", {30'd0, state_o}, 1);
      chk("t6_no_rst", wdt_rst_req_o, 0);
      wait_until("t6_rst", 1, 100, n); chk("t6_rst_lat", n, 21);
      cfg_enable_i = 0; tick(3);
      rst_ni = 0; #1;
      chk("t6_arst_req", wdt_rst_req_o, 0);
      chk("t6_arst_state", {30'd0, state_o}, 0);
      chk("t6_arst_exp", {24'd0, expire_cnt_o}, 0);
      chk("t6_arst_clr", cnt_clear_o, 1);
      tick(); rst_ni = 1; tick();
      // Repeated bad kicks saturate the expiry count.
      kick_i = 1; kick_key_i = 0; arm(100, 80);
      tick(18 * 260);
      chk("t7_sat", {24'd0, expire_cnt_o}, 255);
      kick_i = 0; cfg_enable_i = 0; tick(20);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
